// File: rtl/npu_mmio_initiator_if.sv
// Command, response and MMIO pin bundle for the TinyNPU host-side initiator.
// The master modport is the initiator's view; slave is the host/harness side.
`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 8
`endif
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 32
`endif

interface npu_mmio_initiator_if #(
    parameter int ADDR_W = `MMIO_ADDR_WIDTH,
    parameter int DATA_W = `HOST_DATA_WIDTH
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_wr_en;
    logic [DATA_W-1:0] host_rd_data;
    logic              all_done;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, host_rd_data, all_done,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, host_addr, host_wr_data, host_wr_en
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, host_rd_data, all_done,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, host_addr, host_wr_data, host_wr_en
    );
endinterface

// File: rtl/npu_mmio_initiator.sv
// Host-side MMIO bus master for the TinyNPU control slave: executes one
// WRITE / READ / WAIT_DONE command at a time and returns one response each.
`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 8
`endif
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 32
`endif

module npu_mmio_initiator #(
    parameter int ADDR_W     = `MMIO_ADDR_WIDTH,
    parameter int DATA_W     = `HOST_DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    npu_mmio_initiator_if.master bus,
    output logic                 busy
);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;
    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_WAIT,
        S_POLL,
        S_RESP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rsp_data_q;
    logic                 rsp_err_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [TIMEOUT_W-1:0] poll_cnt;
    logic [TIMEOUT_W-1:0] poll_cnt_inc;
    logic [1:0]           lat_cnt;
    logic                 accept;
    logic                 timeout_hit;
    logic                 read_ready;

    assign accept       = (state == S_IDLE) && bus.cmd_valid;
    assign poll_cnt_inc = poll_cnt + TIMEOUT_W'(1);
    // A zero timeout never expires; all_done is checked ahead of this so done wins a tie.
    assign timeout_hit  = (timeout_q != '0) && (poll_cnt_inc == timeout_q);
    assign read_ready   = (lat_cnt == LAT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_WRITE: state_next = S_WRITE;
                        OP_READ:  state_next = S_READ_WAIT;
                        OP_WAIT:  state_next = S_POLL;
                        default:  state_next = S_RESP;
                    endcase
                end
            end
            S_WRITE:     state_next = S_RESP;
            S_READ_WAIT: if (read_ready) state_next = S_RESP;
            S_POLL:      if (bus.all_done || timeout_hit) state_next = S_RESP;
            S_RESP:      if (bus.rsp_ready) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            timeout_q  <= '0;
            poll_cnt   <= '0;
            lat_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_cnt   <= '0;
                        poll_cnt  <= '0;
                        timeout_q <= bus.cmd_wdata[TIMEOUT_W-1:0];
                        // Reserved ops leave the bus pins untouched and fail straight away.
                        if (bus.cmd_op == 2'b11) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                        end else begin
                            addr_q  <= bus.cmd_addr;
                            wdata_q <= bus.cmd_wdata;
                        end
                    end
                end
                S_WRITE: begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                end
                S_READ_WAIT: begin
                    if (read_ready) begin
                        rsp_data_q <= bus.host_rd_data;
                        rsp_err_q  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_POLL: begin
                    if (bus.all_done) begin
                        rsp_data_q <= DATA_W'(1);
                        rsp_err_q  <= 1'b0;
                    end else begin
                        poll_cnt <= poll_cnt_inc;
                        if (timeout_hit) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.cmd_ready    = (state == S_IDLE);
        bus.rsp_valid    = (state == S_RESP);
        bus.rsp_data     = (state == S_RESP) ? rsp_data_q : '0;
        bus.rsp_err      = (state == S_RESP) && rsp_err_q;
        bus.host_wr_en   = (state == S_WRITE);
        bus.host_addr    = addr_q;
        bus.host_wr_data = wdata_q;
        busy             = (state != S_IDLE);
    end
endmodule

// File: tb/tb_npu_mmio_initiator.sv
// Self-checking bench for npu_mmio_initiator: directed table, reset corner
// cases and randomized commands scored against a command-level model.
`timescale 1ns/1ps

module tb_npu_mmio_initiator;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;
    localparam int LIMIT  = 80;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          done_at;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] ref_addr;

    npu_mmio_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    npu_mmio_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .TIMEOUT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slaveWord(input logic [7:0] a);
        if (a == 8'h08) return 32'h0000_1234;
        return {a, ~a, a ^ 8'h3C, 8'hC3};
    endfunction

    // Slave model: read data appears one cycle after the address
    always_ff @(posedge clk) bus.host_rd_data <= slaveWord(bus.host_addr);

    function automatic vec_t predict(input vec_t v);
        vec_t r;
        int   to;
        r  = v;
        to = int'(v.wdata[15:0]);
        r.exp_data = 32'h0;
        r.exp_err  = 1'b0;
        case (v.op)
            2'b00: r.exp_lat = 2;
            2'b01: begin
                r.exp_data = slaveWord(v.addr);
                r.exp_lat  = 2 + RD_LAT;
            end
            2'b10: begin
                if (v.done_at >= 1 && (to == 0 || v.done_at <= to)) begin
                    r.exp_data = 32'h1;
                    r.exp_lat  = v.done_at + 1;
                end else begin
                    r.exp_err = 1'b1;
                    r.exp_lat = to + 1;
                end
            end
            default: begin
                r.exp_err = 1'b1;
                r.exp_lat = 1;
            end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int          k;
        int          lat;
        int          wr_cnt;
        int          wr_first;
        int          bad_hold;
        logic [31:0] got_data;
        logic        got_err;
        logic [7:0]  wr_addr;
        logic [31:0] wr_data;
        lat = -1; wr_cnt = 0; wr_first = -1; bad_hold = 0;
        wr_addr = 8'h0; wr_data = 32'h0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.all_done  = 1'b0;
        bus.rsp_ready = 1'b0;
        k = 0;
        while (!bus.cmd_ready && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        checkOutput("cmd_accept", 32'(bus.cmd_ready), 32'h1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        if (v.op != 2'b11) ref_addr = v.addr;
        for (k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            // Junk commands while busy must be ignored
            bus.cmd_op    = 2'($urandom_range(0, 3));
            bus.cmd_addr  = 8'($urandom);
            bus.cmd_wdata = $urandom;
            bus.all_done  = (v.done_at > 0 && k >= v.done_at);
            if (bus.host_wr_en) begin
                wr_cnt++;
                if (wr_first < 0) begin
                    wr_first = k;
                    wr_addr  = bus.host_addr;
                    wr_data  = bus.host_wr_data;
                end
            end
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
        checkOutput("rsp_latency", 32'(lat), 32'(v.exp_lat));
        if (lat < 0) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        got_data = bus.rsp_data;
        got_err  = bus.rsp_err;
        checkOutput("rsp_data", got_data, v.exp_data);
        checkOutput("rsp_err", 32'(got_err), 32'(v.exp_err));
        checkOutput("wr_pulses", 32'(wr_cnt), (v.op == 2'b00) ? 32'h1 : 32'h0);
        if (v.op == 2'b00) begin
            checkOutput("wr_cycle", 32'(wr_first), 32'h1);
            checkOutput("wr_addr", 32'(wr_addr), 32'(v.addr));
            checkOutput("wr_data", wr_data, v.wdata);
        end
        checkOutput("host_addr", 32'(bus.host_addr), 32'(ref_addr));
        for (int h = 0; h < v.hold; h++) begin
            if (!bus.rsp_valid || bus.rsp_data !== got_data || bus.rsp_err !== got_err ||
                bus.cmd_ready || bus.host_wr_en)
                bad_hold++;
            @(negedge clk);
            bus.all_done = 1'($urandom_range(0, 1));
        end
        if (!bus.rsp_valid || bus.rsp_data !== got_data || bus.rsp_err !== got_err) bad_hold++;
        checkOutput("rsp_hold", 32'(bad_hold), 32'h0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("ready_after_rsp", 32'(bus.cmd_ready), 32'h1);
        checkOutput("no_bypass", 32'(busy), 32'h0);
        checkOutput("rsp_dropped", 32'(bus.rsp_valid), 32'h0);
        bus.cmd_valid = 1'b0;
        bus.all_done  = 1'b0;
    endtask

    task automatic resetMidOp(input logic [1:0] op);
        int stale;
        stale = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = 8'h08;
        bus.cmd_wdata = 32'hDEAD_BEEF;
        bus.all_done  = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("busy_before_rst", 32'(busy), 32'h1);
        if (op == 2'b00) checkOutput("wr_en_before_rst", 32'(bus.host_wr_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst_wr_en", 32'(bus.host_wr_en), 32'h0);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        ref_addr = 8'h0;
        bus.rsp_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) stale++;
        end
        checkOutput("no_stale_rsp", 32'(stale), 32'h0);
        checkOutput("idle_after_rst", 32'(bus.cmd_ready), 32'h1);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [31:0] r;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 8'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.all_done  = 1'b0;
        ref_addr      = 8'h0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("reset_wr_en", 32'(bus.host_wr_en), 32'h0);
        checkOutput("reset_host_addr", 32'(bus.host_addr), 32'h0);
        checkOutput("reset_rsp_data", bus.rsp_data, 32'h0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        rst_n = 1'b1;

        // {op, addr, wdata, done_at (0 = never), hold, exp_data, exp_err, exp_lat}
        tbl.push_back('{2'b00, 8'h04, 32'h0000_00A5, 0,  0, 32'h0,         1'b0, 2});
        tbl.push_back('{2'b01, 8'h08, 32'h0,         0,  2, 32'h0000_1234, 1'b0, 3});
        tbl.push_back('{2'b10, 8'h00, 32'd10,        5,  0, 32'h1,         1'b0, 6});
        tbl.push_back('{2'b10, 8'h00, 32'd3,         0,  0, 32'h0,         1'b1, 4});
        tbl.push_back('{2'b11, 8'h77, 32'h0000_FFFF, 0,  0, 32'h0,         1'b1, 1});
        tbl.push_back('{2'b00, 8'h10, 32'hCAFE_0001, 0,  7, 32'h0,         1'b0, 2});
        tbl.push_back('{2'b10, 8'h00, 32'hABCD_0004, 4,  0, 32'h1,         1'b0, 5});
        tbl.push_back('{2'b10, 8'h00, 32'h0,         20, 1, 32'h1,         1'b0, 21});
        tbl.push_back('{2'b01, 8'h3C, 32'h0,         0,  7, 32'h3CC3_00C3, 1'b0, 3});
        tbl.push_back('{2'b10, 8'h00, 32'd2,         3,  0, 32'h0,         1'b1, 3});
        foreach (tbl[i]) applyStimulus(tbl[i]);

        resetMidOp(2'b01);
        resetMidOp(2'b00);

        for (int i = 0; i < 40; i++) begin
            v.op    = 2'($urandom_range(0, 3));
            v.addr  = 8'($urandom);
            r       = $urandom;
            v.done_at = 0;
            if (v.op == 2'b10) begin
                r[15:0]   = 16'($urandom_range(0, 12));
                v.done_at = $urandom_range(0, 15);
                if (r[15:0] == 16'h0 && v.done_at == 0) v.done_at = $urandom_range(1, 15);
            end
            v.wdata = r;
            v.hold  = $urandom_range(0, 3);
            v = predict(v);
            applyStimulus(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
